// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq -- HI/LO multiply/divide sequencer for the MIPS core.
//
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring) over 32
// iterations plus a sign-fixup cycle, and owns the HI/LO registers.
// MTHI/MTLO write in one idle cycle, and MFHI/MFLO read combinationally.
//
// Optional build macro: MIPS_MULDIV_FAST_MUL_EN. When it is defined,
// MULT/MULTU use a single-cycle hardware multiply (IDLE -> FIX).
// DIV/DIVU are the same in both builds.
//
// Handshake: an operation is accepted on a rising edge when start_i is
// high, busy_o is low and funct_i is one of the eight known codes.
// A known request that arrives while busy_o is high raises stall_o.
// The requester must hold start_i until stall_o drops; requests are
// not queued. An unknown funct is ignored and never stalls.
//
// Ports:
//   clk_i, reset_i     clock and asynchronous active-high reset
//   start_i, funct_i   issue strobe and funct code
//   a_i, b_i           rs / rt operands
//   busy_o             operation in flight
//   stall_o            issuer must hold its request
//   done_o             one-cycle pulse after HI/LO are written by MULT*/DIV*
//   hi_o, lo_o         HI/LO registers
//   mf_data_o          HI for MFHI, LO for MFLO, otherwise 0
//   dbg_state_o        FSM state, exposed for debug

module mips_muldiv_seq (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mf_data_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;

  state_t state, state_n;

  logic [4:0]  cnt;
  logic [63:0] acc;        // product (mul) or remainder:quotient (div)
  logic [31:0] opnd;       // multiplicand (mul) or divisor (div)
  logic        sign_a;     // dividend / multiplicand was negative
  logic        sign_b;
  logic        op_div;
  logic        div0;

  logic        known, is_mul, is_div, is_signed, accept;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] rem33;
  logic [31:0] diff32;
  logic [63:0] mul_res;
  logic [31:0] q_fix, r_fix;
`ifdef MIPS_MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
`endif

  // Decode and datapath helpers
  always_comb begin
    known     = funct_i inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                F_MULT, F_MULTU, F_DIV, F_DIVU};
    is_mul    = (funct_i == F_MULT) || (funct_i == F_MULTU);
    is_div    = (funct_i == F_DIV)  || (funct_i == F_DIVU);
    is_signed = (funct_i == F_MULT) || (funct_i == F_DIV);
    accept    = start_i && (state == S_IDLE) && known;
    abs_a     = (is_signed && a_i[31]) ? (32'd0 - a_i) : a_i;
    abs_b     = (is_signed && b_i[31]) ? (32'd0 - b_i) : b_i;
    // Shift-add step: add multiplicand to the upper half when LSB is set.
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    // Restoring step: the shifted partial remainder needs 33 bits.
    rem33     = acc[63:31];
    diff32    = rem33[31:0] - opnd;
    mul_res   = (sign_a ^ sign_b) ? (64'd0 - acc) : acc;
    q_fix     = ((sign_a ^ sign_b) && !div0) ? (32'd0 - acc[31:0])  : acc[31:0];
    r_fix     = (sign_a && !div0)            ? (32'd0 - acc[63:32]) : acc[63:32];
`ifdef MIPS_MULDIV_FAST_MUL_EN
    if (funct_i == F_MULT)
      fast_prod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    else
      fast_prod = {32'd0, a_i} * {32'd0, b_i};
`endif
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul) begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
          state_n = S_FIX;
`else
          state_n = S_MUL;
`endif
        end else if (accept && is_div) begin
          state_n = S_DIV;
        end
      end
      S_MUL, S_DIV: if (cnt == 5'd31) state_n = S_FIX;
      S_FIX:        state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o      = (state != S_IDLE);
    stall_o     = start_i && busy_o && known;
    dbg_state_o = state;
    if (funct_i == F_MFHI)      mf_data_o = hi_o;
    else if (funct_i == F_MFLO) mf_data_o = lo_o;
    else                        mf_data_o = 32'd0;
  end

  // Datapath and HI/LO
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      op_div <= 1'b0;
      div0   <= 1'b0;
      hi_o   <= 32'd0;
      lo_o   <= 32'd0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (funct_i == F_MTHI) hi_o <= a_i;
            if (funct_i == F_MTLO) lo_o <= a_i;
            if (is_mul || is_div) begin
              cnt    <= 5'd0;
              op_div <= is_div;
              div0   <= is_div && (b_i == 32'd0);
              sign_a <= is_signed && a_i[31];
              sign_b <= is_signed && b_i[31];
              if (is_div) begin
                opnd <= abs_b;
                acc  <= {32'd0, abs_a};
              end else begin
                opnd <= abs_a;
                acc  <= {32'd0, abs_b};
`ifdef MIPS_MULDIV_FAST_MUL_EN
                // Product is already signed; suppress the FIX negation.
                acc    <= fast_prod;
                sign_a <= 1'b0;
                sign_b <= 1'b0;
`endif
              end
            end
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 5'd1;
        end
        S_DIV: begin
          if (rem33 >= {1'b0, opnd}) acc <= {diff32, acc[30:0], 1'b1};
          else                       acc <= {acc[62:0], 1'b0};
          cnt <= cnt + 5'd1;
        end
        S_FIX: begin
          done_o <= 1'b1;
          cnt    <= 5'd0;
          if (op_div) begin
            hi_o <= r_fix;
            lo_o <= q_fix;
          end else begin
            hi_o <= mul_res[63:32];
            lo_o <= mul_res[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_seq.sv
module tb_mips_muldiv_seq;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MIPS_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] hi, lo, mf_data;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mips_muldiv_seq dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .funct_i(funct),
    .a_i(a), .b_i(b), .busy_o(busy), .stall_o(stall), .done_o(done),
    .hi_o(hi), .lo_o(lo), .mf_data_o(mf_data), .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic from the instruction definitions.
  function automatic void ref_model(input logic [5:0] f, input logic [31:0] x,
                                    input logic [31:0] y,
                                    output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    p  = 64'd0;
    case (f)
      F_MULT:  p = sx * sy;
      F_MULTU: p = {32'd0, x} * {32'd0, y};
      F_DIV: begin
        q = sx / sy;
        r = sx % sy;
        p = {r[31:0], q[31:0]};
      end
      F_DIVU: begin
        if (y == 32'd0) p = {x, 32'hFFFFFFFF};
        else            p = {{32'd0, x} % {32'd0, y}, 32'd0} | ({32'd0, x} / {32'd0, y});
      end
      default: p = 64'd0;
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  // driver: issue a MULT*/DIV* and check latency, done pulse and HI/LO
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int lat, n;
    ref_model(f, x, y, eh, el);
    lat = (f == F_MULT || f == F_MULTU) ? MUL_LAT : DIV_LAT;
    @(negedge clk);
    start = 1'b1; funct = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; funct = 6'h00;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"},  32'(n), 32'(lat));
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"},   hi, eh);
    chk({tag, "_lo"},   lo, el);
    exp_hi = eh;
    exp_lo = el;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] eh, el;
    logic [5:0]  ftab [4];
    logic [5:0]  f;
    logic [31:0] x, y;
    int n, miss;

    ftab[0] = F_MULT; ftab[1] = F_MULTU; ftab[2] = F_DIV; ftab[3] = F_DIVU;
    reset = 1'b1; start = 1'b0; funct = 6'h00; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    // MTHI, then MFLO and MFHI in separate idle cycles
    @(negedge clk);
    start = 1'b1; funct = F_MTHI; a = 32'h12345678;
    @(posedge clk); #1 start = 1'b0; funct = 6'h00;
    exp_hi = 32'h12345678;
    @(negedge clk);
    start = 1'b1; funct = F_MFLO; #1;
    chk("mflo_data", mf_data, 32'h00000000);
    chk("mflo_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 start = 1'b0; funct = 6'h00;
    @(negedge clk);
    chk("mt_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; funct = F_MFHI; #1;
    chk("mfhi_data", mf_data, 32'h12345678);
    @(posedge clk); #1 start = 1'b0; funct = 6'h00;
    @(negedge clk);
    chk("mf_busy", {31'd0, busy}, 32'd0);
    chk("mf_done", {31'd0, done}, 32'd0);

    // unknown funct is ignored
    start = 1'b1; funct = 6'h20; a = 32'hCAFEF00D; #1;
    chk("unk_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 start = 1'b0; funct = 6'h00;
    @(negedge clk);
    chk("unk_busy", {31'd0, busy}, 32'd0);
    chk("unk_hi", hi, exp_hi);

    // directed arithmetic
    run_op("mult_neg",  F_MULT,  32'hFFFFFFFE, 32'h00000003);
    chk("mult_neg_hi_k", hi, 32'hFFFFFFFF);
    run_op("multu",     F_MULTU, 32'hFFFFFFFE, 32'h00000003);
    chk("multu_hi_k", hi, 32'h00000002);
    run_op("div_neg",   F_DIV,   32'hFFFFFFF9, 32'h00000002);
    chk("div_neg_lo_k", lo, 32'hFFFFFFFD);
    run_op("divu_zero", F_DIVU,  32'h00000007, 32'h00000000);
    chk("divu_zero_lo_k", lo, 32'hFFFFFFFF);
    run_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo_k", lo, 32'h80000000);
    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max_hi_k", hi, 32'hFFFFFFFE);

    // MFLO held from 5 cycles after a DIV accept
    ref_model(F_DIV, 32'hFFFFFF9C, 32'd7, eh, el);
    @(negedge clk);
    start = 1'b1; funct = F_DIV; a = 32'hFFFFFF9C; b = 32'd7;
    @(posedge clk); #1 start = 1'b0; funct = 6'h00;
    repeat (5) @(negedge clk);
    start = 1'b1; funct = F_MFLO; #1;
    n = 0; miss = 0;
    while (busy && n < 100) begin
      if (!stall) miss++;
      n++;
      @(negedge clk); #1;
    end
    chk("mf_hold_stall_miss", 32'(miss), 32'd0);
    chk("mf_hold_cycles", 32'(n), 32'd29);
    chk("mf_hold_done", {31'd0, done}, 32'd1);
    chk("mf_hold_nostall", {31'd0, stall}, 32'd0);
    chk("mf_hold_data", mf_data, el);
    @(posedge clk); #1 start = 1'b0; funct = 6'h00;
    exp_hi = eh; exp_lo = el;

    // MTLO held during a DIVU is stalled and never lands
    ref_model(F_DIVU, 32'd1000, 32'd33, eh, el);
    @(negedge clk);
    start = 1'b1; funct = F_DIVU; a = 32'd1000; b = 32'd33;
    @(posedge clk); #1 start = 1'b0; funct = 6'h00;
    repeat (3) @(negedge clk);
    start = 1'b1; funct = F_MTLO; a = 32'hDEADBEEF;
    miss = 0;
    repeat (6) begin
      #1 if (!stall) miss++;
      @(negedge clk);
    end
    start = 1'b0; funct = 6'h00;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk("mt_busy_stall_miss", 32'(miss), 32'd0);
    chk("mt_busy_done", {31'd0, done}, 32'd1);
    chk("mt_busy_hi", hi, eh);
    chk("mt_busy_lo", lo, el);
    exp_hi = eh; exp_lo = el;

    // asynchronous reset mid-operation (DIVU when the multiply is single-cycle)
    f = (MUL_LAT == 33) ? F_MULTU : F_DIVU;
    @(negedge clk);
    start = 1'b1; funct = f; a = 32'h00012345; b = 32'h00000777;
    @(posedge clk); #1 start = 1'b0; funct = 6'h00;
    repeat (10) @(negedge clk);
    chk("abort_pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst", F_MULTU, 32'd3, 32'd5);
    chk("post_rst_lo_k", lo, 32'd15);

    // randomized operations against the reference model
    for (int i = 0; i < 10; i++) begin
      f = ftab[$urandom_range(0, 3)];
      x = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 5000));
      y = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) y = 32'd0 - y;
      if (f == F_DIV && y == 32'd0) y = 32'd3;
      run_op($sformatf("rnd%0d", i), f, x, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
